edp_muldiv_seq: RTL and testbench

- Step sequencer for the EDP AR/ARX/MQ/BR datapath during fixed-point multiply and divide.
- On a start pulse from CTL it owns the AD function select, the AR/ARX load strobes and the MQ shift select for a fixed number of steps, then hands control back.
- Multiply uses radix-4 Booth recoding, one step per cycle.
- Divide is non-restoring, one quotient bit per cycle, with a final remainder fixup.

---
 rtl/edp_muldiv_pkg.sv | 40 ++++
 rtl/edp_booth_dec.sv | 26 ++
 rtl/edp_muldiv_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_edp_muldiv_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edp_muldiv_pkg.sv
// ----------------------------------------------------------------------------
// edp_muldiv_pkg
//
// Shared types and defaults for the EDP multiply/divide step sequencer.
//   state_e   : sequencer states
//   ad_op_e   : AD function select codes driven on ad_op_h
//   mq_sel_e  : MQ select codes driven on ctl_mq_sel_h
//   *_DEF     : default step counts and counter width
// ----------------------------------------------------------------------------
package edp_muldiv_pkg;

    localparam int MUL_STEPS_DEF = 18;  // 36-bit multiplier, 2 bits per Booth step
    localparam int DIV_STEPS_DEF = 36;  // one quotient bit per step
    localparam int CNT_W_DEF     = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MUL       = 3'd1,
        ST_DIV_FIRST = 3'd2,
        ST_DIV       = 3'd3,
        ST_DIV_FIX   = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        AD_PASS = 3'd0,   // AR
        AD_ADD  = 3'd1,   // AR + BR
        AD_ADD2 = 3'd2,   // AR + 2BR
        AD_SUB  = 3'd3,   // AR - BR
        AD_SUB2 = 3'd4    // AR - 2BR
    } ad_op_e;

    typedef enum logic [1:0] {
        MQ_HOLD = 2'd0,
        MQ_SHR2 = 2'd1,   // shift right 2, AD low bits in
        MQ_SHL1 = 2'd2,   // shift left 1, quotient bit in
        MQ_LOAD = 2'd3
    } mq_sel_e;

endpackage

// File: rtl/edp_booth_dec.sv
// ----------------------------------------------------------------------------
// edp_booth_dec
//
// Radix-4 Booth recoder: maps the multiplier triple to an AD function.
// Purely combinational; also used by the EDP self-test checker.
//   triple_h [2:0] in  : {mq_34, mq_35, booth_prev}
//   ad_op_h        out : AD function select (ad_op_e)
// ----------------------------------------------------------------------------
module edp_booth_dec
    import edp_muldiv_pkg::*;
(
    input  logic [2:0] triple_h,
    output ad_op_e     ad_op_h
);

    always_comb begin
        case (triple_h)
            3'b000, 3'b111: ad_op_h = AD_PASS;
            3'b001, 3'b010: ad_op_h = AD_ADD;
            3'b011:         ad_op_h = AD_ADD2;
            3'b100:         ad_op_h = AD_SUB2;
            default:        ad_op_h = AD_SUB;   // 101, 110
        endcase
    end

endmodule

// File: rtl/edp_muldiv_seq.sv
// ----------------------------------------------------------------------------
// edp_muldiv_seq
//
// Step sequencer for the EDP AR/ARX/MQ/BR datapath during fixed-point
// multiply (radix-4 Booth, one step per cycle) and divide (non-restoring,
// one quotient bit per cycle, final remainder fixup).
//
// Optional feature macro: EDP_MUL_EARLY_TERM_EN
//   Adds input mq_rest_eq_sign_h and ends a multiply early once the
//   remaining multiplier bits can only recode to "pass".
//
// Ports
//   clk_edp_h          in   EDP clock
//   mr_reset_l         in   synchronous active-low reset
//   start_mul_h        in   1-cycle pulse, begin multiply (IDLE only)
//   start_div_h        in   1-cycle pulse, begin divide (IDLE only)
//   kill_h             in   abort, back to IDLE next cycle
//   mq_34_h, mq_35_h   in   multiplier bits from MQ
//   mq_rest_eq_sign_h  in   (feature only) unconsumed MQ bits == booth_prev
//   ad_neg_h           in   sign of current AD result
//   ad_op_h       [2:0] out AD function select
//   ctl_arr_load_l     out  AR/ARX load strobe, active low
//   ctl_mq_sel_h  [1:0] out MQ select
//   quo_bit_h          out  quotient bit into MQ bit 35
//   busy_h             out  sequencer not IDLE
//   done_h             out  1-cycle completion pulse
//   no_divide_h        out  divide overflow, pulses with done_h
//
// Every output is a flop: the command for a step appears the cycle after
// the FSM was in that step.
// ----------------------------------------------------------------------------
module edp_muldiv_seq
    import edp_muldiv_pkg::*;
#(
    parameter int MUL_STEPS = MUL_STEPS_DEF,
    parameter int DIV_STEPS = DIV_STEPS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic       clk_edp_h,
    input  logic       mr_reset_l,
    input  logic       start_mul_h,
    input  logic       start_div_h,
    input  logic       kill_h,
    input  logic       mq_34_h,
    input  logic       mq_35_h,
`ifdef EDP_MUL_EARLY_TERM_EN
    input  logic       mq_rest_eq_sign_h,
`endif
    input  logic       ad_neg_h,
    output logic [2:0] ad_op_h,
    output logic       ctl_arr_load_l,
    output logic [1:0] ctl_mq_sel_h,
    output logic       quo_bit_h,
    output logic       busy_h,
    output logic       done_h,
    output logic       no_divide_h
);

    // ---------------------------------------------------------------- state
    state_e             state_q,      state_d;
    logic [CNT_W-1:0]   count_q,      count_d;
    logic               booth_prev_q, booth_prev_d;
    logic               prev_neg_q,   prev_neg_d;
    logic               nodiv_q,      nodiv_d;      // overflow seen, report in DONE

    // ------------------------------------------------------- output flops
    ad_op_e             ad_op_q,      ad_op_d;
    logic               arr_load_l_q, arr_load_l_d;
    mq_sel_e            mq_sel_q,     mq_sel_d;
    logic               quo_bit_q,    quo_bit_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;
    logic               no_divide_q,  no_divide_d;

    // ------------------------------------------------------- Booth recode
    logic [2:0] triple;
    ad_op_e     booth_op;
    logic       early_term;

    assign triple = {mq_34_h, mq_35_h, booth_prev_q};

    edp_booth_dec u_booth_dec (
        .triple_h (triple),
        .ad_op_h  (booth_op)
    );

`ifdef EDP_MUL_EARLY_TERM_EN
    // Remaining multiplier bits all match the sign run: every further step
    // would be a pass, so the residual shift is left to the shifter.
    assign early_term = mq_rest_eq_sign_h && ((triple == 3'b000) || (triple == 3'b111));
`else
    assign early_term = 1'b0;
`endif

    // ------------------------------------------------- next state / outputs
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        booth_prev_d = booth_prev_q;
        prev_neg_d   = prev_neg_q;
        nodiv_d      = nodiv_q;

        ad_op_d      = AD_PASS;
        arr_load_l_d = 1'b1;
        mq_sel_d     = MQ_HOLD;
        quo_bit_d    = 1'b0;
        busy_d       = (state_q != ST_IDLE);
        done_d       = 1'b0;
        no_divide_d  = 1'b0;

        if (kill_h) begin
            // Abort outranks every transition; strobes stay at their defaults.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_mul_h) begin
                        state_d      = ST_MUL;
                        count_d      = CNT_W'(MUL_STEPS - 1);
                        booth_prev_d = 1'b0;
                    end else if (start_div_h) begin
                        state_d = ST_DIV_FIRST;
                        nodiv_d = 1'b0;
                    end
                end

                ST_MUL: begin
                    ad_op_d      = booth_op;
                    arr_load_l_d = 1'b0;
                    mq_sel_d     = MQ_SHR2;
                    booth_prev_d = mq_34_h;
                    if ((count_q == '0) || early_term) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end

                ST_DIV_FIRST: begin
                    // Trial subtract only; a non-negative result means the
                    // quotient cannot fit, so nothing is ever loaded.
                    ad_op_d = AD_SUB;
                    if (!ad_neg_h) begin
                        state_d = ST_DONE;
                        nodiv_d = 1'b1;
                    end else begin
                        state_d    = ST_DIV;
                        count_d    = CNT_W'(DIV_STEPS - 1);
                        prev_neg_d = 1'b1;
                    end
                end

                ST_DIV: begin
                    // Non-restoring: add back after a negative partial
                    // remainder, subtract after a non-negative one.
                    ad_op_d      = prev_neg_q ? AD_ADD : AD_SUB;
                    arr_load_l_d = 1'b0;
                    mq_sel_d     = MQ_SHL1;
                    quo_bit_d    = ~ad_neg_h;
                    prev_neg_d   = ad_neg_h;
                    if (count_q == '0) begin
                        state_d = ST_DIV_FIX;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end

                ST_DIV_FIX: begin
                    // A negative final remainder is restored by adding BR once.
                    if (prev_neg_q) begin
                        ad_op_d      = AD_ADD;
                        arr_load_l_d = 1'b0;
                    end
                    state_d = ST_DONE;
                end

                ST_DONE: begin
                    done_d      = 1'b1;
                    no_divide_d = nodiv_q;
                    nodiv_d     = 1'b0;
                    state_d     = ST_IDLE;
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ registers
    // NOTE: reset is sampled on the clock edge, not in the sensitivity list,
    // so a mid-operation reset simply behaves like a kill that also clears
    // the counter.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_edp_h) begin
        if (!mr_reset_l) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            booth_prev_q <= 1'b0;
            prev_neg_q   <= 1'b0;
            nodiv_q      <= 1'b0;
            ad_op_q      <= AD_PASS;
            arr_load_l_q <= 1'b1;
            mq_sel_q     <= MQ_HOLD;
            quo_bit_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            no_divide_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            booth_prev_q <= booth_prev_d;
            prev_neg_q   <= prev_neg_d;
            nodiv_q      <= nodiv_d;
            ad_op_q      <= ad_op_d;
            arr_load_l_q <= arr_load_l_d;
            mq_sel_q     <= mq_sel_d;
            quo_bit_q    <= quo_bit_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            no_divide_q  <= no_divide_d;
        end
    end

    assign ad_op_h        = ad_op_q;
    assign ctl_arr_load_l = arr_load_l_q;
    assign ctl_mq_sel_h   = mq_sel_q;
    assign quo_bit_h      = quo_bit_q;
    assign busy_h         = busy_q;
    assign done_h         = done_q;
    assign no_divide_h    = no_divide_q;

endmodule

// File: tb/tb_edp_muldiv_seq.sv
// ----------------------------------------------------------------------------
// tb_edp_muldiv_seq
//
// Self-checking bench for edp_muldiv_seq. Multiply is checked against Booth
// digit weights derived from the multiplier value and the product rebuilt
// from the observed AD commands; divide is checked against integer quotient
// and remainder, with the remainder rebuilt from the observed commands.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_edp_muldiv_seq;

    localparam int MUL_STEPS = 18;
    localparam int DIV_STEPS = 36;

    logic       clk_edp_h;
    logic       mr_reset_l;
    logic       start_mul_h;
    logic       start_div_h;
    logic       kill_h;
    logic       mq_34_h;
    logic       mq_35_h;
`ifdef EDP_MUL_EARLY_TERM_EN
    logic       mq_rest_eq_sign_h;
`endif
    logic       ad_neg_h;
    logic [2:0] ad_op_h;
    logic       ctl_arr_load_l;
    logic [1:0] ctl_mq_sel_h;
    logic       quo_bit_h;
    logic       busy_h;
    logic       done_h;
    logic       no_divide_h;

    int n_cmp = 0;
    int n_bad = 0;

    edp_muldiv_seq dut (
        .clk_edp_h         (clk_edp_h),
        .mr_reset_l        (mr_reset_l),
        .start_mul_h       (start_mul_h),
        .start_div_h       (start_div_h),
        .kill_h            (kill_h),
        .mq_34_h           (mq_34_h),
        .mq_35_h           (mq_35_h),
`ifdef EDP_MUL_EARLY_TERM_EN
        .mq_rest_eq_sign_h (mq_rest_eq_sign_h),
`endif
        .ad_neg_h          (ad_neg_h),
        .ad_op_h           (ad_op_h),
        .ctl_arr_load_l    (ctl_arr_load_l),
        .ctl_mq_sel_h      (ctl_mq_sel_h),
        .quo_bit_h         (quo_bit_h),
        .busy_h            (busy_h),
        .done_h            (done_h),
        .no_divide_h       (no_divide_h)
    );

    initial clk_edp_h = 1'b0;
    always #5 clk_edp_h = ~clk_edp_h;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Booth digit value -> AD function code, and back.
    function automatic int op_of_digit(input int w);
        case (w)
            1:       return 1;
            2:       return 2;
            -1:      return 3;
            -2:      return 4;
            default: return 0;
        endcase
    endfunction

    function automatic longint digit_of_op(input int op);
        case (op)
            1:       return 1;
            2:       return 2;
            3:       return -1;
            4:       return -2;
            default: return 0;
        endcase
    endfunction

    // Multiply m (36-bit two's complement) by br. The bench plays MQ: step i
    // presents multiplier bits 2i+1/2i. kill_step >= 0 aborts at that step.
    task automatic mul_run(input logic [35:0] m, input longint br,
                           input bit both, input int kill_step);
        logic [36:0] mx;
        longint      acc;
        longint      prod;
        int          w;
        mx   = {m, 1'b0};   // bit 0 stands for the implicit bit -1
        acc  = 0;
        prod = longint'($signed(m)) * br;
        start_mul_h = 1'b1;
        start_div_h = both;
        @(negedge clk_edp_h);
        start_mul_h = 1'b0;
        start_div_h = 1'b0;
        for (int e = 1; e <= MUL_STEPS + 1; e++) begin
            int i;
            i = e - 1;
            if (i < MUL_STEPS) begin
                mq_34_h = mx[2*i+2];
                mq_35_h = mx[2*i+1];
            end else begin
                mq_34_h = 1'b0;
                mq_35_h = 1'b0;
            end
            kill_h = (i == kill_step);
            @(negedge clk_edp_h);
            kill_h = 1'b0;
            if (i == kill_step) begin
                check("kill_busy", busy_h, 0);
                check("kill_done", done_h, 0);
                check("kill_load", ctl_arr_load_l, 1);
                check("kill_mqsel", ctl_mq_sel_h, 0);
                return;
            end
            if (i < MUL_STEPS) begin
                w = -2 * int'(mx[2*i+2]) + int'(mx[2*i+1]) + int'(mx[2*i]);
                check($sformatf("mul_op_step%0d", i), ad_op_h, op_of_digit(w));
                check("mul_load", ctl_arr_load_l, 0);
                check("mul_mqsel", ctl_mq_sel_h, 1);
                check("mul_busy", busy_h, 1);
                check("mul_done_early", done_h, 0);
                acc += digit_of_op(int'(ad_op_h)) * br * (longint'(1) << (2*i));
            end else begin
                check("mul_done", done_h, 1);
                check("mul_done_busy", busy_h, 1);
                check("mul_done_load", ctl_arr_load_l, 1);
                check("mul_no_div", no_divide_h, 0);
            end
        end
        @(negedge clk_edp_h);
        check("mul_done_pulse", done_h, 0);
        check("mul_idle_busy", busy_h, 0);
        check("mul_product", acc, prod);
    endtask

    // Divide x by d. The bench plays the AD sign: non-negative partial
    // remainder after step i exactly when quotient bit 35-i is 1.
    task automatic div_run(input longint x, input longint d);
        bit          ovf;
        longint      q;
        longint      r;
        longint      rr;
        logic [35:0] qb;
        logic [35:0] qo;
        ovf = (d == 0) || (x >= (d << 35));
        q   = 0;
        r   = 0;
        if (!ovf) begin
            q = x / d;
            r = x % d;
        end
        qb = q[35:0];
        qo = '0;
        start_div_h = 1'b1;
        @(negedge clk_edp_h);
        start_div_h = 1'b0;
        ad_neg_h    = !ovf;
        @(negedge clk_edp_h);
        check("div_trial_op", ad_op_h, 3);
        check("div_trial_load", ctl_arr_load_l, 1);
        check("div_trial_busy", busy_h, 1);
        if (ovf) begin
            ad_neg_h = 1'b0;
            @(negedge clk_edp_h);
            check("ovf_done", done_h, 1);
            check("ovf_no_div", no_divide_h, 1);
            check("ovf_load", ctl_arr_load_l, 1);
            @(negedge clk_edp_h);
            check("ovf_done_pulse", done_h, 0);
            check("ovf_no_div_pulse", no_divide_h, 0);
            check("ovf_idle_busy", busy_h, 0);
            return;
        end
        rr = x - (d << 36);   // trial subtract, taken as the starting point
        for (int i = 0; i < DIV_STEPS; i++) begin
            int exp_op;
            ad_neg_h = ~qb[35-i];
            @(negedge clk_edp_h);
            if (i == 0) exp_op = 1;
            else        exp_op = qb[36-i] ? 3 : 1;
            check($sformatf("div_op_step%0d", i), ad_op_h, exp_op);
            check("div_load", ctl_arr_load_l, 0);
            check("div_mqsel", ctl_mq_sel_h, 2);
            check("div_done_early", done_h, 0);
            qo = {qo[34:0], quo_bit_h};
            if (ad_op_h == 3'd1) rr += d * (longint'(1) << (35 - i));
            else                 rr -= d * (longint'(1) << (35 - i));
        end
        ad_neg_h = 1'b0;
        @(negedge clk_edp_h);
        check("div_fix_op", ad_op_h, qb[0] ? 0 : 1);
        check("div_fix_load", ctl_arr_load_l, qb[0] ? 1 : 0);
        if (ad_op_h == 3'd1 && ctl_arr_load_l == 1'b0) rr += d;
        @(negedge clk_edp_h);
        check("div_done", done_h, 1);
        check("div_no_div", no_divide_h, 0);
        check("div_done_busy", busy_h, 1);
        check("div_quotient", qo, qb);
        check("div_remainder", rr, r);
        @(negedge clk_edp_h);
        check("div_done_pulse", done_h, 0);
        check("div_idle_busy", busy_h, 0);
    endtask

    initial begin
        logic [63:0] rnd;
        longint      d;
        longint      x;

        mr_reset_l  = 1'b0;
        start_mul_h = 1'b1;
        start_div_h = 1'b0;
        kill_h      = 1'b0;
        mq_34_h     = 1'b0;
        mq_35_h     = 1'b0;
        ad_neg_h    = 1'b0;
`ifdef EDP_MUL_EARLY_TERM_EN
        mq_rest_eq_sign_h = 1'b0;
`endif

        // Reset with a start held: everything stays at reset values.
        repeat (3) @(negedge clk_edp_h);
        check("rst_ad_op", ad_op_h, 0);
        check("rst_load", ctl_arr_load_l, 1);
        check("rst_mqsel", ctl_mq_sel_h, 0);
        check("rst_quo", quo_bit_h, 0);
        check("rst_busy", busy_h, 0);
        check("rst_done", done_h, 0);
        check("rst_no_div", no_divide_h, 0);
        mr_reset_l  = 1'b1;
        start_mul_h = 1'b0;
        repeat (2) @(negedge clk_edp_h);
        check("post_rst_busy", busy_h, 0);

        // Directed: 5 x 3, 100 / 7, overflow cases.
        mul_run(36'd3, 5, 1'b0, -1);
        div_run(100, 7);
        div_run(100, 0);
        div_run(longint'(7) << 35, 7);

        // Kill at multiply step 7, then a full divide starts right after.
        mul_run(36'h9_8765_4321, 1234, 1'b0, 7);
        div_run(123456789, 1000);

        // Both starts together: multiply wins.
        mul_run(36'hF_FFFF_FFF7, -77, 1'b1, -1);

        // Reset in the middle of a divide.
        start_div_h = 1'b1;
        @(negedge clk_edp_h);
        start_div_h = 1'b0;
        ad_neg_h    = 1'b1;
        repeat (5) @(negedge clk_edp_h);
        mr_reset_l = 1'b0;
        @(negedge clk_edp_h);
        check("midrst_busy", busy_h, 0);
        check("midrst_load", ctl_arr_load_l, 1);
        check("midrst_mqsel", ctl_mq_sel_h, 0);
        mr_reset_l = 1'b1;
        ad_neg_h   = 1'b0;
        @(negedge clk_edp_h);

        // Randomized operands.
        for (int k = 0; k < 6; k++) begin
            rnd = {$urandom, $urandom};
            mul_run(rnd[35:0], longint'($urandom_range(0, 65535)) - 32768, 1'b0, -1);
        end
        for (int k = 0; k < 6; k++) begin
            rnd = {$urandom, $urandom};
            d   = longint'($urandom_range(1, 1 << 20));
            x   = longint'(rnd & 64'h7FFF_FFFF_FFFF_FFFF) % (d << 35);
            div_run(x, d);
        end

`ifdef EDP_MUL_EARLY_TERM_EN
        // Zero multiplier with the rest-equal flag: one step, then DONE.
        mq_rest_eq_sign_h = 1'b1;
        mq_34_h     = 1'b0;
        mq_35_h     = 1'b0;
        start_mul_h = 1'b1;
        start_div_h = 1'b1;
        @(negedge clk_edp_h);
        start_mul_h = 1'b0;
        start_div_h = 1'b0;
        @(negedge clk_edp_h);
        check("et_op", ad_op_h, 0);
        check("et_mqsel", ctl_mq_sel_h, 1);
        @(negedge clk_edp_h);
        check("et_done", done_h, 1);
        check("et_mqsel_done", ctl_mq_sel_h, 0);
        mq_rest_eq_sign_h = 1'b0;
        @(negedge clk_edp_h);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
